branch_resolve_unit: RTL and testbench

- Execute-side counterpart of the fetch-stage branch predictor.
- Fetch pushes each conditional branch's prediction (PC, predicted direction, predicted target) into an in-order in-flight queue.
- Execute resolves the oldest entry, detects mispredictions and drives one-cycle flush/redirect plus a predictor-update pulse.
- Keeps saturating performance counters for resolved branches and mispredictions.

---
 rtl/branch_resolve_unit.sv | 139 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Execute-side partner of the fetch branch predictor. Fetch pushes each
//   conditional branch's prediction into an in-order in-flight queue; execute
//   resolves the oldest entry. Mispredictions produce a one-cycle flush with the
//   correct fetch PC, and every resolve produces a predictor-update pulse.
//   Saturating counters track resolved branches and mispredictions.
//
// Ports
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   push_valid/pc/pred/pred_target fetch-side push of one predicted branch
//   push_ready                     queue not full (depends on occupancy only)
//   resolve_valid/taken/target     execute-side resolution of the oldest branch
//   flush, redirect_pc             registered squash pulse and correct fetch PC
//   upd_valid, upd_taken           registered predictor-update pulse and outcome
//   resolve_error                  registered pulse: resolve with an empty queue
//   q_count                        current queue occupancy
//   branch_count, mispredict_count saturating performance counters
//
// Handshake: a push is accepted on a rising edge where push_valid && push_ready;
// a resolve is accepted where resolve_valid && q_count != 0. Neither side may
// assume acceptance otherwise; all results appear one cycle after acceptance.

module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid,
    input  logic [XLEN-1:0]            push_pc,
    input  logic                       push_pred,
    input  logic [XLEN-1:0]            push_pred_target,
    output logic                       push_ready,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic [XLEN-1:0]            resolve_target,
    output logic                       flush,
    output logic [XLEN-1:0]            redirect_pc,
    output logic                       upd_valid,
    output logic                       upd_taken,
    output logic                       resolve_error,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic [CNT_W-1:0]           branch_count,
    output logic [CNT_W-1:0]           mispredict_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0]    FULL_C  = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Queue storage
    logic [XLEN-1:0]  pc_mem  [DEPTH];
    logic             pred_mem[DEPTH];
    logic [XLEN-1:0]  tgt_mem [DEPTH];

    logic [PTR_W-1:0] head_q, tail_q;
    logic [CW-1:0]    count_q;

    logic             flush_q, upd_valid_q, upd_taken_q, resolve_error_q;
    logic [XLEN-1:0]  redirect_q;
    logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

    logic             push_acc, res_acc, mispredict;
    logic             head_pred;
    logic [XLEN-1:0]  head_pc, head_tgt, correct_pc;

    assign push_ready = (count_q != FULL_C);
    assign push_acc   = push_valid && push_ready;
    assign res_acc    = resolve_valid && (count_q != '0);

    assign head_pc   = pc_mem[head_q];
    assign head_pred = pred_mem[head_q];
    assign head_tgt  = tgt_mem[head_q];

    // Wrong direction, or right "taken" direction but wrong target.
    assign mispredict = res_acc &&
                        ((resolve_taken != head_pred) ||
                         (resolve_taken && head_pred && (resolve_target != head_tgt)));

    assign correct_pc = resolve_taken ? resolve_target : (head_pc + XLEN'(4));

    // Storage has no reset; pointers and occupancy define which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && push_acc && !mispredict) begin
            pc_mem[tail_q]   <= push_pc;
            pred_mem[tail_q] <= push_pred;
            tgt_mem[tail_q]  <= push_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            flush_q         <= 1'b0;
            redirect_q      <= '0;
            upd_valid_q     <= 1'b0;
            upd_taken_q     <= 1'b0;
            resolve_error_q <= 1'b0;
            branch_cnt_q    <= '0;
            mispred_cnt_q   <= '0;
        end else begin
            flush_q         <= mispredict;
            upd_valid_q     <= res_acc;
            resolve_error_q <= resolve_valid && (count_q == '0);
            if (mispredict) redirect_q  <= correct_pc;
            if (res_acc)    upd_taken_q <= resolve_taken;

            if (res_acc && (branch_cnt_q != CNT_MAX))
                branch_cnt_q <= branch_cnt_q + 1'b1;
            if (mispredict && (mispred_cnt_q != CNT_MAX))
                mispred_cnt_q <= mispred_cnt_q + 1'b1;

            if (mispredict) begin
                // Everything younger is wrong-path, including a same-cycle push.
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push_acc) tail_q <= tail_q + 1'b1;
                if (res_acc)  head_q <= head_q + 1'b1;
                count_q <= count_q + CW'(push_acc) - CW'(res_acc);
            end
        end
    end

    assign flush            = flush_q;
    assign redirect_pc      = redirect_q;
    assign upd_valid        = upd_valid_q;
    assign upd_taken        = upd_taken_q;
    assign resolve_error    = resolve_error_q;
    assign q_count          = count_q;
    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid, push_pred, resolve_valid, resolve_taken;
    logic [31:0] push_pc, push_pred_target, resolve_target;

    logic        push_ready, flush, upd_valid, upd_taken, resolve_error;
    logic [31:0] redirect_pc, branch_count, mispredict_count;
    logic [2:0]  q_count;

    // Narrow-counter copy driven by the same stimulus, used for saturation.
    logic        s_push_ready, s_flush, s_upd_valid, s_upd_taken, s_resolve_error;
    logic [31:0] s_redirect_pc;
    logic [2:0]  s_q_count;
    logic [3:0]  s_branch_count, s_mispredict_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(4), .XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_pc(push_pc), .push_pred(push_pred),
        .push_pred_target(push_pred_target), .push_ready(push_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_taken(upd_taken),
        .resolve_error(resolve_error), .q_count(q_count),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_resolve_unit #(.DEPTH(4), .XLEN(32), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_pc(push_pc), .push_pred(push_pred),
        .push_pred_target(push_pred_target), .push_ready(s_push_ready),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .flush(s_flush), .redirect_pc(s_redirect_pc),
        .upd_valid(s_upd_valid), .upd_taken(s_upd_taken),
        .resolve_error(s_resolve_error), .q_count(s_q_count),
        .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs held across the rising edge; outputs are
    // then sampled 1 time unit after that edge.
    task automatic step(input logic pv, input logic [31:0] ppc, input logic pp,
                        input logic [31:0] pt, input logic rv, input logic rtk,
                        input logic [31:0] rtg);
        push_valid = pv; push_pc = ppc; push_pred = pp; push_pred_target = pt;
        resolve_valid = rv; resolve_taken = rtk; resolve_target = rtg;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic push(input logic [31:0] ppc, input logic pp, input logic [31:0] pt);
        step(1'b1, ppc, pp, pt, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic rtk, input logic [31:0] rtg);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rtk, rtg);
    endtask

    initial begin
        reset = 1'b1;
        push_valid = 1'b0; push_pc = '0; push_pred = 1'b0; push_pred_target = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
        idle();
        idle();
        check("rst_q_count", q_count, 0);
        check("rst_push_ready", push_ready, 1);
        check("rst_flush", flush, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_upd_taken", upd_taken, 0);
        check("rst_resolve_error", resolve_error, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_branch_count", branch_count, 0);
        check("rst_mispredict_count", mispredict_count, 0);
        reset = 1'b0;
        idle();

        // Correct not-taken prediction
        push(32'h100, 1'b0, 32'h0);
        check("t1_q_after_push", q_count, 1);
        resolve(1'b0, 32'h0);
        check("t1_upd_valid", upd_valid, 1);
        check("t1_upd_taken", upd_taken, 0);
        check("t1_flush", flush, 0);
        check("t1_branch_count", branch_count, 1);
        check("t1_q_count", q_count, 0);
        idle();
        check("t1_upd_pulse_end", upd_valid, 0);

        // Predicted taken, actually not taken -> redirect to pc+4
        push(32'h200, 1'b1, 32'h240);
        resolve(1'b0, 32'h0);
        check("t2_flush", flush, 1);
        check("t2_redirect_pc", redirect_pc, 32'h204);
        check("t2_mispredict_count", mispredict_count, 1);
        check("t2_branch_count", branch_count, 2);
        idle();
        check("t2_flush_end", flush, 0);
        check("t2_redirect_hold", redirect_pc, 32'h204);

        // Taken with wrong target; same-cycle push is wrong-path
        push(32'h300, 1'b1, 32'h340);
        step(1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b1, 32'h380);
        check("t3_flush", flush, 1);
        check("t3_redirect_pc", redirect_pc, 32'h380);
        check("t3_upd_taken", upd_taken, 1);
        check("t3_q_count", q_count, 0);
        check("t3_mispredict_count", mispredict_count, 2);
        idle();
        check("t3_flush_end", flush, 0);
        check("t3_q_still_empty", q_count, 0);

        // Shift pointers off zero so the fill below wraps
        push(32'h480, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        check("t4_pre_branch_count", branch_count, 4);

        push(32'h500, 1'b1, 32'h520);
        push(32'h600, 1'b0, 32'h0);
        push(32'h700, 1'b1, 32'h760);
        push(32'h800, 1'b0, 32'h0);
        check("t4_full_q_count", q_count, 4);
        check("t4_full_push_ready", push_ready, 0);
        push(32'h900, 1'b1, 32'h999);
        check("t4_push_when_full", q_count, 4);
        // Push while full with a same-cycle pop: push still dropped
        step(1'b1, 32'hA00, 1'b1, 32'hAAA, 1'b1, 1'b1, 32'h520);
        check("t4_A_q_count", q_count, 3);
        check("t4_A_upd_valid", upd_valid, 1);
        check("t4_A_upd_taken", upd_taken, 1);
        check("t4_A_flush", flush, 0);
        resolve(1'b0, 32'h0);
        check("t4_B_flush", flush, 0);
        check("t4_B_q_count", q_count, 2);
        resolve(1'b1, 32'h760);
        check("t4_C_flush", flush, 0);
        check("t4_C_upd_taken", upd_taken, 1);
        resolve(1'b0, 32'h0);
        check("t4_D_flush", flush, 0);
        check("t4_D_q_count", q_count, 0);
        check("t4_branch_count", branch_count, 8);
        check("t4_mispredict_count", mispredict_count, 2);

        // Empty-queue resolve
        resolve(1'b1, 32'h123);
        check("t5_resolve_error", resolve_error, 1);
        check("t5_upd_valid", upd_valid, 0);
        check("t5_flush", flush, 0);
        check("t5_branch_count", branch_count, 8);
        check("t5_mispredict_count", mispredict_count, 2);
        idle();
        check("t5_error_pulse_end", resolve_error, 0);

        // Push alongside a correct resolve is kept
        push(32'hB00, 1'b1, 32'hB40);
        step(1'b1, 32'hC00, 1'b0, 32'h0, 1'b1, 1'b1, 32'hB40);
        check("t6_q_count", q_count, 1);
        check("t6_flush", flush, 0);
        resolve(1'b0, 32'h0);
        check("t6_second_flush", flush, 0);
        check("t6_second_q_count", q_count, 0);
        check("t6_branch_count", branch_count, 10);

        // Mispredicting resolve in the same cycle as reset: no flush
        push(32'hD00, 1'b0, 32'h0);
        reset = 1'b1;
        resolve(1'b1, 32'hD80);
        check("t7_flush", flush, 0);
        check("t7_q_count", q_count, 0);
        check("t7_mispredict_count", mispredict_count, 0);
        check("t7_redirect_pc", redirect_pc, 0);
        reset = 1'b0;
        idle();
        check("t7_flush_after", flush, 0);

        // 20 correct resolves: 4-bit counter saturates at 15
        push(32'h1000, 1'b0, 32'h0);
        for (int i = 1; i < 20; i++)
            step(1'b1, 32'h1000 + 32'(i) * 32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        check("t8_sat_branch_count", s_branch_count, 15);
        check("t8_wide_branch_count", branch_count, 20);
        check("t8_sat_mispredict", s_mispredict_count, 0);
        check("t8_q_count", q_count, 0);
        resolve(1'b0, 32'h0);
        check("t8_sat_after_error", s_branch_count, 15);
        check("t8_sat_error", s_resolve_error, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
